// File: rtl/debounce_pkg.sv
// Shared state encodings and decode helper for the per-bit debounce FSM.
// The FSM's data level is the msb of its state code.
package debounce_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_LOW       = 2'd0;
    localparam state_t ST_RISE_WAIT = 2'd1;
    localparam state_t ST_HIGH      = 2'd2;
    localparam state_t ST_FALL_WAIT = 2'd3;

    // Accepted level of a state: high once the rise is accepted, until the fall is.
    function automatic logic level_of(input state_t st);
        return st[1];
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input bit: 2-flop synchronizer, then a four-state Moore FSM.
// The stability counter is only meaningful in the two wait states.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw,
    output logic level,
    output logic level_next
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 sync_meta_r;
    logic                 sync_r;
    state_t               state_r;
    state_t               state_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_s;

    // Two-flop synchronizer for the asynchronous raw level.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_meta_r <= 1'b0;
            sync_r      <= 1'b0;
        end else begin
            sync_meta_r <= raw;
            sync_r      <= sync_meta_r;
        end
    end

    // Present-state and counter register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_LOW;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic; the >= test keeps the counter from ever running past its last value.
    always_comb begin
        state_s = ST_LOW;
        cnt_s   = CNT_ZERO;
        case (state_r)
            ST_LOW: begin
                if (sync_r) begin
                    state_s = ST_RISE_WAIT;
                end else begin
                    state_s = ST_LOW;
                end
            end
            ST_RISE_WAIT: begin
                if (!sync_r) begin
                    state_s = ST_LOW;
                end else if (cnt_r >= CNT_LAST) begin
                    state_s = ST_HIGH;
                end else begin
                    state_s = ST_RISE_WAIT;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync_r) begin
                    state_s = ST_FALL_WAIT;
                end else begin
                    state_s = ST_HIGH;
                end
            end
            ST_FALL_WAIT: begin
                if (sync_r) begin
                    state_s = ST_HIGH;
                end else if (cnt_r >= CNT_LAST) begin
                    state_s = ST_LOW;
                end else begin
                    state_s = ST_FALL_WAIT;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_LOW;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output decode from state; level_next lets the top register a coincident change strobe.
    always_comb begin
        level      = level_of(state_r);
        level_next = level_of(state_s);
    end

endmodule

// File: rtl/dual_input_debouncer.sv
// Two independent debounced inputs feeding a downstream FSM's 2-bit Data_In.
// Change is registered from the channels' next levels so it lines up with the new Data_Out.
module dual_input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] Raw_In,
    output logic [1:0] Data_Out,
    output logic       Change
);

    logic [1:0] level_s;
    logic [1:0] level_next_s;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_chan0 (
        .Clock      (Clock),
        .Reset      (Reset),
        .raw        (Raw_In[0]),
        .level      (level_s[0]),
        .level_next (level_next_s[0])
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_chan1 (
        .Clock      (Clock),
        .Reset      (Reset),
        .raw        (Raw_In[1]),
        .level      (level_s[1]),
        .level_next (level_next_s[1])
    );

    assign Data_Out = level_s;

    // One strobe per edge on which either or both levels change.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Change <= 1'b0;
        end else begin
            Change <= (level_next_s != level_s);
        end
    end

endmodule

// File: tb/tb_dual_input_debouncer.sv
// Self-checking bench for dual_input_debouncer with DEBOUNCE_CYCLES=4.
// Reference model: run length of synchronized samples disagreeing with the accepted level.
module tb_dual_input_debouncer;

    localparam int N = 4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [1:0] Raw_In = 2'b00;
    logic [1:0] Data_Out;
    logic       Change;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    logic [1:0] m_s1, m_s2, m_out;
    logic       m_chg;
    int         m_run [2];

    dual_input_debouncer #(
        .DEBOUNCE_CYCLES (N),
        .CNT_WIDTH       (16)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Raw_In   (Raw_In),
        .Data_Out (Data_Out),
        .Change   (Change)
    );

    always #5 Clock = ~Clock;

    task automatic model_reset();
        m_s1 = 2'b00; m_s2 = 2'b00; m_out = 2'b00; m_chg = 1'b0;
        m_run[0] = 0; m_run[1] = 0;
    endtask

    // A level is accepted after N+1 consecutive disagreeing samples, seen two edges after capture.
    task automatic model_step(input logic [1:0] r);
        logic [1:0] samp;
        logic [1:0] prev;
        samp = m_s2; m_s2 = m_s1; m_s1 = r; prev = m_out;
        for (int b = 0; b < 2; b++) begin
            if (samp[b] != m_out[b]) begin
                m_run[b]++;
                if (m_run[b] == N + 1) begin
                    m_out[b] = samp[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_chg = (m_out != prev);
    endtask

    // Drive Raw_In in the low phase, take one rising edge, advance the model, settle 1 time unit.
    task automatic step_edge(input logic [1:0] r);
        if (Clock) @(negedge Clock);
        Raw_In = r;
        @(posedge Clock);
        model_step(r);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Raw_In = 2'b11;
        model_reset();
        #12;
        n_checks++;
        if (Data_Out !== 2'b00 || Change !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: Data_Out=%b Change=%b, expected 00 0", Data_Out, Change);
        end
        Raw_In = 2'b00;
        Reset = 1'b0;
    endtask

    task automatic test_latency();
        for (int i = 0; i < 8; i++) begin
            step_edge(2'b11);
            n_checks++;
            if (Data_Out !== m_out || Change !== m_chg) begin
                n_errors++;
                $display("FAIL latency_model e%0d: Data_Out=%b Change=%b, expected %b %b", i, Data_Out, Change, m_out, m_chg);
            end
            n_checks++;
            if (Data_Out !== ((i >= 6) ? 2'b11 : 2'b00) || Change !== (i == 6)) begin
                n_errors++;
                $display("FAIL latency_edge e%0d: Data_Out=%b Change=%b", i, Data_Out, Change);
            end
        end
    endtask

    task automatic test_fall();
        int flip_at;
        int pulses;
        flip_at = -1; pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step_edge(2'b01);
            if (Change === 1'b1) pulses++;
            if (flip_at < 0 && Data_Out === 2'b01) flip_at = i;
            n_checks++;
            if (Data_Out !== m_out || Change !== m_chg) begin
                n_errors++;
                $display("FAIL fall_model e%0d: Data_Out=%b Change=%b, expected %b %b", i, Data_Out, Change, m_out, m_chg);
            end
        end
        n_checks++;
        if (flip_at !== 6 || pulses !== 1) begin
            n_errors++;
            $display("FAIL fall_timing: flip edge %0d pulses %0d, expected 6 1", flip_at, pulses);
        end
    endtask

    task automatic test_glitch();
        int seen_chg;
        seen_chg = 0;
        @(negedge Clock);
        Reset = 1'b1; Raw_In = 2'b00;
        model_reset();
        #2 Reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step_edge((i >= 2 && i < 5) ? 2'b01 : 2'b00);
            if (Change === 1'b1) seen_chg++;
            n_checks++;
            if (Data_Out !== m_out || Change !== m_chg) begin
                n_errors++;
                $display("FAIL glitch_model e%0d: Data_Out=%b Change=%b, expected %b %b", i, Data_Out, Change, m_out, m_chg);
            end
        end
        n_checks++;
        if (Data_Out !== 2'b00 || seen_chg !== 0) begin
            n_errors++;
            $display("FAIL glitch_filtered: Data_Out=%b pulses %0d, expected 00 0", Data_Out, seen_chg);
        end
    endtask

    task automatic test_bounce();
        logic [1:0] pattern [6];
        int flip_at;
        pattern = '{2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10};
        flip_at = -1;
        for (int i = 0; i < 14; i++) begin
            step_edge((i < 6) ? pattern[i] : 2'b10);
            if (flip_at < 0 && Data_Out[1] === 1'b1) flip_at = i;
            n_checks++;
            if (Data_Out !== m_out || Change !== m_chg) begin
                n_errors++;
                $display("FAIL bounce_model e%0d: Data_Out=%b Change=%b, expected %b %b", i, Data_Out, Change, m_out, m_chg);
            end
        end
        // last 0 captured on edge 1, stable 1 from edge 2, accepted six edges later
        n_checks++;
        if (flip_at !== 8) begin
            n_errors++;
            $display("FAIL bounce_restart: rise at edge %0d, expected 8", flip_at);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) step_edge(2'b11);
        // leave FALL_WAIT with cnt=2 after the fifth low sample edge
        for (int i = 0; i < 5; i++) step_edge(2'b00);
        n_checks++;
        if (Data_Out !== 2'b11 || m_out !== 2'b11) begin
            n_errors++;
            $display("FAIL midcount_level: Data_Out=%b, expected 11", Data_Out);
        end
        @(negedge Clock);
        #2 Reset = 1'b1;
        #1;
        n_checks++;
        if (Data_Out !== 2'b00 || Change !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: Data_Out=%b Change=%b, expected 00 0", Data_Out, Change);
        end
        model_reset();
        #1 Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step_edge(2'b11);
            n_checks++;
            if (Data_Out !== ((i >= 6) ? 2'b11 : 2'b00) || Data_Out !== m_out || Change !== m_chg) begin
                n_errors++;
                $display("FAIL reset_restart e%0d: Data_Out=%b Change=%b, expected %b %b", i, Data_Out, Change, m_out, m_chg);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] r;
        int hold;
        r = 2'b00; hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                r = 2'($urandom_range(0, 3));
                hold = int'($urandom_range(1, 9));
            end
            hold--;
            step_edge(r);
            n_checks++;
            if (Data_Out !== m_out || Change !== m_chg) begin
                n_errors++;
                $display("FAIL random e%0d: Data_Out=%b Change=%b, expected %b %b", i, Data_Out, Change, m_out, m_chg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fall();
        test_glitch();
        test_bounce();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
